// File: rtl/data_router_pkg.sv
// Types shared across the data router: reg_array commands and sequencer states.
package data_router_pkg;

    typedef enum logic [1:0] {
        BUFIN = 2'b00,
        SHIFT = 2'b01,
        FIFOI = 2'b10,
        HOLD  = 2'b11
    } reg_cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        WIN,
        DONE
    } seq_state_e;

    // Index width for a counter over n positions, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_array_seq_if.sv
// Sequencer-side bus: buffer read, FIFO pop, reg_array command and PE window handshake.
interface reg_array_seq_if #(
    parameter int AW = 10,
    parameter int RW = 8,
    parameter int KW = 2
);
    import data_router_pkg::*;

    logic          o_buf_rd_en;
    logic [AW-1:0] o_buf_rd_addr;
    logic          o_fifo_rd_en;
    logic          i_fifo_empty;
    reg_cmd_e      o_reg_array_cmd;
    logic          o_pe_valid;
    logic          i_pe_ready;
    logic [KW-1:0] o_kx;
    logic [KW-1:0] o_ky;
    logic [RW-1:0] o_oy;

    modport master (
        output o_buf_rd_en, o_buf_rd_addr, o_fifo_rd_en, o_reg_array_cmd,
               o_pe_valid, o_kx, o_ky, o_oy,
        input  i_fifo_empty, i_pe_ready
    );

    modport slave (
        input  o_buf_rd_en, o_buf_rd_addr, o_fifo_rd_en, o_reg_array_cmd,
               o_pe_valid, o_kx, o_ky, o_oy,
        output i_fifo_empty, i_pe_ready
    );

endinterface

// File: rtl/reg_array_seq.sv
// Command sequencer for one reg_array: fetches kernel rows, shifts through every
// horizontal kernel position and presents each window to the PE row.
//
// state | meaning
// IDLE  | waiting for start, reg_array held
// FETCH | issue buffer read or FIFO pop for kernel row ky
// LOAD  | fetched row lands in reg_array (BUFIN/FIFOI)
// WIN   | window (oy,ky,kx) valid for the PEs
// DONE  | one-cycle job-complete pulse
module reg_array_seq
    import data_router_pkg::*;
#(
    parameter int KSIZE    = 3,
    parameter int STRIDE   = 1,
    parameter int AW       = 10,
    parameter int RW       = 8,
    parameter int USE_FIFO = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [RW-1:0] i_rows,
    input  logic [AW-1:0] i_base_addr,
    output logic          o_busy,
    output logic          o_done,
    reg_array_seq_if.master bus
);
    localparam int            KW       = idx_width(KSIZE);
    localparam logic [KW-1:0] K_LAST   = KW'(KSIZE - 1);
    localparam logic [AW-1:0] STRIDE_A = AW'(STRIDE);

    seq_state_e    state, state_nx;
    logic [RW-1:0] rows_q, oy, oy_nx;
    logic [AW-1:0] base_q;
    logic [KW-1:0] kx, kx_nx, ky, ky_nx;
    logic          from_fifo, last_kx, last_ky, last_oy;

    assign from_fifo = (USE_FIFO != 0) && (ky != '0);
    assign last_kx   = (kx == K_LAST);
    assign last_ky   = (ky == K_LAST);
    assign last_oy   = (oy == rows_q - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rows_q <= '0;
            base_q <= '0;
            oy     <= '0;
            ky     <= '0;
            kx     <= '0;
        end else begin
            state <= state_nx;
            oy    <= oy_nx;
            ky    <= ky_nx;
            kx    <= kx_nx;
            if (state == IDLE && i_start) begin
                rows_q <= i_rows;
                base_q <= i_base_addr;
            end
        end
    end

    always_comb begin
        state_nx            = state;
        oy_nx               = oy;
        ky_nx               = ky;
        kx_nx               = kx;
        bus.o_buf_rd_en     = 1'b0;
        bus.o_fifo_rd_en    = 1'b0;
        bus.o_reg_array_cmd = HOLD;
        bus.o_pe_valid      = 1'b0;
        o_done              = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_start) begin
                    oy_nx    = '0;
                    ky_nx    = '0;
                    kx_nx    = '0;
                    state_nx = (i_rows == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (!from_fifo) begin
                    bus.o_buf_rd_en = 1'b1;
                    state_nx        = LOAD;
                end else if (!bus.i_fifo_empty) begin
                    bus.o_fifo_rd_en = 1'b1;
                    state_nx         = LOAD;
                end
            end
            LOAD: begin
                if (from_fifo) bus.o_reg_array_cmd = FIFOI;
                else           bus.o_reg_array_cmd = BUFIN;
                kx_nx    = '0;
                state_nx = WIN;
            end
            WIN: begin
                bus.o_pe_valid = 1'b1;
                // Without ready the command stays HOLD so the window cannot move.
                if (bus.i_pe_ready) begin
                    if (!last_kx) begin
                        bus.o_reg_array_cmd = SHIFT;
                        kx_nx               = kx + 1'b1;
                    end else if (!last_ky) begin
                        ky_nx    = ky + 1'b1;
                        state_nx = FETCH;
                    end else if (!last_oy) begin
                        oy_nx    = oy + 1'b1;
                        ky_nx    = '0;
                        state_nx = FETCH;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                o_done   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Address wraps modulo 2^AW by truncation.
    assign bus.o_buf_rd_addr = bus.o_buf_rd_en ? (base_q + AW'(oy) * STRIDE_A + AW'(ky)) : '0;
    assign bus.o_kx          = (state == WIN) ? kx : '0;
    assign bus.o_ky          = (state == WIN) ? ky : '0;
    assign bus.o_oy          = (state == WIN) ? oy : '0;
    assign o_busy            = (state != IDLE);

endmodule

// File: tb/tb_reg_array_seq.sv
// Bench for reg_array_seq: two instances (FIFO-fed stride 1, buffer-only stride 2)
// checked against a job-level reference of expected reads, pops, windows and length.
module tb_reg_array_seq;
    import data_router_pkg::*;

    localparam int K = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [7:0] rows_in = '0;
    logic [9:0] base_in = '0;
    logic       ready = 1'b1, empty = 1'b0;
    logic       busy_a, done_a, busy_b, done_b;

    reg_array_seq_if #(.AW(10), .RW(8), .KW(2)) bus_a ();
    reg_array_seq_if #(.AW(10), .RW(8), .KW(2)) bus_b ();

    assign bus_a.i_pe_ready   = ready;
    assign bus_a.i_fifo_empty = empty;
    assign bus_b.i_pe_ready   = ready;
    assign bus_b.i_fifo_empty = empty;

    reg_array_seq #(.KSIZE(3), .STRIDE(1), .AW(10), .RW(8), .USE_FIFO(1)) dut_a (
        .clk(clk), .rst(rst), .i_start(start_a), .i_rows(rows_in), .i_base_addr(base_in),
        .o_busy(busy_a), .o_done(done_a), .bus(bus_a)
    );

    reg_array_seq #(.KSIZE(3), .STRIDE(2), .AW(10), .RW(8), .USE_FIFO(0)) dut_b (
        .clk(clk), .rst(rst), .i_start(start_b), .i_rows(rows_in), .i_base_addr(base_in),
        .o_busy(busy_b), .o_done(done_b), .bus(bus_b)
    );

    always #5 clk = ~clk;

    int         sel = 0;
    logic       s_rd, s_pop, s_valid, s_busy, s_done;
    logic [9:0] s_addr;
    logic [1:0] s_cmd, s_kx, s_ky;
    logic [7:0] s_oy;

    always_comb begin
        if (sel == 0) begin
            s_rd = bus_a.o_buf_rd_en;  s_addr = bus_a.o_buf_rd_addr; s_pop = bus_a.o_fifo_rd_en;
            s_cmd = bus_a.o_reg_array_cmd; s_valid = bus_a.o_pe_valid;
            s_kx = bus_a.o_kx; s_ky = bus_a.o_ky; s_oy = bus_a.o_oy; s_busy = busy_a; s_done = done_a;
        end else begin
            s_rd = bus_b.o_buf_rd_en;  s_addr = bus_b.o_buf_rd_addr; s_pop = bus_b.o_fifo_rd_en;
            s_cmd = bus_b.o_reg_array_cmd; s_valid = bus_b.o_pe_valid;
            s_kx = bus_b.o_kx; s_ky = bus_b.o_ky; s_oy = bus_b.o_oy; s_busy = busy_b; s_done = done_b;
        end
    end

    int total = 0;
    int bad   = 0;
    int rd_ts[$], rd_addrs[$], pop_ts[$], val_ts[$];
    logic [1:0] cmd_log [64];
    int         kx_log  [64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs change just after the edge, outputs are sampled 1 ns later.
    task automatic cyc(input logic st_a, input logic st_b, input logic rdy, input logic emp);
        @(posedge clk);
        #1;
        start_a = st_a;
        start_b = st_b;
        ready   = rdy;
        empty   = emp;
        #1;
    endtask

    // Runs one job on instance s. Cycle 0 is the start cycle. Ready is forced low over
    // [drop_at, drop_at+drop_len) and FIFO empty forced high over [emp_at, emp_at+emp_len),
    // otherwise both are randomized with the given percentages; bs_at pulses start mid-job.
    task automatic job(input int s, input int rows, input int base, input int rdy_pct,
                       input int emp_pct, input int drop_at, input int drop_len,
                       input int emp_at, input int emp_len, input int bs_at,
                       output int done_t);
        int exp_rd[$];
        int exp_win[$];
        int n_pop, pops_exp, win_i, stalls, t, obs_w, stride, ew;
        bit uf, awaiting, prev_rd, prev_pop, got_done, rdy, emp;
        sel    = s;
        uf     = (s == 0);
        stride = (s == 0) ? 1 : 2;
        rd_ts.delete(); rd_addrs.delete(); pop_ts.delete(); val_ts.delete();
        for (int i = 0; i < 64; i++) begin
            cmd_log[i] = 2'b00;
            kx_log[i]  = -1;
        end
        for (int oy = 0; oy < rows; oy++) begin
            for (int ky = 0; ky < K; ky++) begin
                if (!uf || ky == 0) exp_rd.push_back((base + oy * stride + ky) % 1024);
                for (int kx = 0; kx < K; kx++) exp_win.push_back(oy * 256 + ky * 16 + kx);
            end
        end
        pops_exp = uf ? rows * (K - 1) : 0;
        rows_in  = 8'(rows);
        base_in  = 10'(base);
        cyc(s == 0, s == 1, 1'b1, 1'b0);
        chk("busy_in_start_cycle", s_busy, 0);
        n_pop = 0; win_i = 0; stalls = 0; t = 0; done_t = -1;
        awaiting = 0; prev_rd = 0; prev_pop = 0; got_done = 0;
        while (!got_done && t < 3000) begin
            t++;
            rdy = !(t >= drop_at && t < drop_at + drop_len) && ($urandom_range(99) >= rdy_pct);
            emp = (t >= emp_at && t < emp_at + emp_len) || ($urandom_range(99) < emp_pct);
            cyc((s == 0) && (t == bs_at), (s == 1) && (t == bs_at), rdy, emp);
            if (t < 64) begin
                cmd_log[t] = s_cmd;
                kx_log[t]  = int'(s_kx);
            end
            ew = (win_i < exp_win.size()) ? exp_win[win_i] : 0;
            chk("busy", s_busy, 1);
            if (prev_rd)                                   chk("cmd_bufin", s_cmd, BUFIN);
            else if (prev_pop)                             chk("cmd_fifoi", s_cmd, FIFOI);
            else if (s_valid && rdy && (ew % 16) < K - 1)  chk("cmd_shift", s_cmd, SHIFT);
            else                                           chk("cmd_hold", s_cmd, HOLD);
            if (awaiting && emp) stalls++;
            if (s_rd) begin
                rd_ts.push_back(t);
                rd_addrs.push_back(int'(s_addr));
                if (exp_rd.size() == 0) chk("extra_read", 1, 0);
                else                    chk("read_addr", s_addr, exp_rd.pop_front());
            end
            if (s_pop) begin
                pop_ts.push_back(t);
                n_pop++;
                chk("pop_while_empty", emp, 0);
                chk("pop_expected", awaiting, 1);
                awaiting = 0;
            end
            if (s_valid) begin
                val_ts.push_back(t);
                obs_w = int'(s_oy) * 256 + int'(s_ky) * 16 + int'(s_kx);
                if (win_i >= exp_win.size()) chk("extra_window", 1, 0);
                else begin
                    chk("window_pos", obs_w, ew);
                    if (rdy) begin
                        if (uf && (ew % 16) == K - 1 && ((ew / 16) % 16) < K - 1) awaiting = 1;
                        win_i++;
                    end else stalls++;
                end
            end
            if (s_done) begin
                got_done = 1;
                done_t   = t;
            end
            prev_rd  = s_rd;
            prev_pop = s_pop;
        end
        chk("done_seen", got_done, 1);
        chk("done_cycle", done_t, (rows == 0) ? 1 : rows * K * (K + 2) + 1 + stalls);
        chk("windows_all", win_i, exp_win.size());
        chk("reads_left", exp_rd.size(), 0);
        chk("pop_count", n_pop, pops_exp);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("idle_busy", s_busy, 0);
        chk("idle_done", s_done, 0);
        chk("idle_valid", s_valid, 0);
        chk("idle_cmd", s_cmd, HOLD);
    endtask

    int dt;
    int vexp[9]     = '{3, 4, 5, 8, 9, 10, 13, 14, 15};
    int rstep_exp[6] = '{'h3FE, 'h3FF, 'h000, 'h000, 'h001, 'h002};

    initial begin
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #0;
            chk("rst_cmd", s_cmd, HOLD);
            chk("rst_valid", s_valid, 0);
            chk("rst_busy", s_busy, 0);
            chk("rst_done", s_done, 0);
            chk("rst_rd", s_rd, 0);
            chk("rst_pop", s_pop, 0);
            chk("rst_idx", {s_oy, s_ky, s_kx}, 0);
            chk("rst_addr", s_addr, 0);
        end
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // basic job
        job(0, 1, 'h010, 0, 0, 0, 0, 0, 0, -1, dt);
        chk("basic_done", dt, 16);
        chk("basic_rd_n", rd_ts.size(), 1);
        chk("basic_rd_t", rd_ts[0], 1);
        chk("basic_rd_a", rd_addrs[0], 'h010);
        chk("basic_pop_n", pop_ts.size(), 2);
        chk("basic_pop0", pop_ts[0], 6);
        chk("basic_pop1", pop_ts[1], 11);
        chk("basic_val_n", val_ts.size(), 9);
        for (int i = 0; i < 9; i++) chk("basic_val_t", val_ts[i], vexp[i]);
        chk("basic_cmd2", cmd_log[2], BUFIN);
        chk("basic_cmd3", cmd_log[3], SHIFT);
        chk("basic_cmd4", cmd_log[4], SHIFT);
        chk("basic_cmd5", cmd_log[5], HOLD);
        chk("basic_cmd7", cmd_log[7], FIFOI);

        // backpressure at kx=1
        job(0, 1, 'h010, 0, 0, 4, 4, 0, 0, -1, dt);
        chk("bp_done", dt, 20);
        for (int t = 4; t < 8; t++) begin
            chk("bp_kx", kx_log[t], 1);
            chk("bp_cmd", cmd_log[t], HOLD);
        end

        // FIFO empty while fetching ky=1
        job(0, 1, 'h010, 0, 0, 0, 0, 6, 3, -1, dt);
        chk("empty_pop_t", pop_ts[0], 9);
        chk("empty_done", dt, 19);

        // row stepping with address wrap
        job(1, 2, 'h3FE, 0, 0, 0, 0, 0, 0, -1, dt);
        chk("rstep_done", dt, 31);
        chk("rstep_rd_n", rd_addrs.size(), 6);
        for (int i = 0; i < 6; i++) chk("rstep_addr", rd_addrs[i], rstep_exp[i]);

        // zero rows
        job(0, 0, 'h123, 0, 0, 0, 0, 0, 0, -1, dt);
        chk("zero_done", dt, 1);
        chk("zero_reads", rd_ts.size(), 0);

        // start while busy is ignored
        job(0, 1, 'h010, 0, 0, 0, 0, 0, 0, 5, dt);
        chk("busy_start_done", dt, 16);

        // reset in the middle of a window
        sel = 0;
        rows_in = 8'd1;
        base_in = 10'h010;
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("mid_pre_valid", s_valid, 1);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("mid_valid", s_valid, 0);
        chk("mid_cmd", s_cmd, HOLD);
        chk("mid_busy", s_busy, 0);
        chk("mid_done", s_done, 0);
        chk("mid_rd_pop", {s_rd, s_pop}, 0);
        rst = 1'b0;
        repeat (3) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            chk("post_rst_done", s_done, 0);
            chk("post_rst_rd_pop", {s_rd, s_pop}, 0);
        end
        job(0, 1, 'h010, 0, 0, 0, 0, 0, 0, -1, dt);
        chk("post_rst_job", dt, 16);

        // randomized jobs on both instances
        for (int j = 0; j < 8; j++)
            job(j % 2, int'($urandom_range(3)), int'($urandom_range(1023)), 30, 40,
                0, 0, 0, 0, -1, dt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
